// File: rtl/ace_kbd_matrix.sv
// ace_kbd_matrix: PS/2 key events and joystick folded into the Jupiter Ace 8x5 keyboard matrix,
// with SHIFT-compound keys and a minimum hold so short taps survive the ROM scan.
module ace_kbd_matrix #(
  parameter int MIN_HOLD = 1040000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick,
  input  logic [7:0]  kbd_row,
  output logic [4:0]  kbd_col
);
  localparam int CW = MIN_HOLD > 1 ? $clog2(MIN_HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD = CW'(MIN_HOLD);
  logic          r_armed;
  logic          r_tog;
  logic [45:0]   r_src;
  logic [45:0]   r_pend;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_col;
  logic          w_hit;
  logic [5:0]    w_idx;
  logic [45:0]   w_bit;
  logic          w_event;
  logic          w_press;
  logic [45:0]   w_pend_n;
  logic          w_expire;
  logic [39:0]   w_key;
  logic [4:0]    w_col;
  // Sources 0..39 are matrix positions row*5+col; 40..45 are BS, ESC, left, down, up, right.
  always_comb begin
    w_hit = 1'b1;
    w_idx = 6'd0;
    case (ps2_key[7:0])
      8'h12: begin w_idx = 6'd0; w_hit = !ps2_key[8]; end
      8'h59: w_idx = 6'd0;
      8'h14: w_idx = 6'd1;
      8'h1A: w_idx = 6'd2;
      8'h22: w_idx = 6'd3;
      8'h21: w_idx = 6'd4;
      8'h1C: w_idx = 6'd5;
      8'h1B: w_idx = 6'd6;
      8'h23: w_idx = 6'd7;
      8'h2B: w_idx = 6'd8;
      8'h34: w_idx = 6'd9;
      8'h15: w_idx = 6'd10;
      8'h1D: w_idx = 6'd11;
      8'h24: w_idx = 6'd12;
      8'h2D: w_idx = 6'd13;
      8'h2C: w_idx = 6'd14;
      8'h16: w_idx = 6'd15;
      8'h1E: w_idx = 6'd16;
      8'h26: w_idx = 6'd17;
      8'h25: w_idx = 6'd18;
      8'h2E: w_idx = 6'd19;
      8'h45: w_idx = 6'd20;
      8'h46: w_idx = 6'd21;
      8'h3E: w_idx = 6'd22;
      8'h3D: w_idx = 6'd23;
      8'h36: w_idx = 6'd24;
      8'h4D: w_idx = 6'd25;
      8'h44: w_idx = 6'd26;
      8'h43: w_idx = 6'd27;
      8'h3C: w_idx = 6'd28;
      8'h35: w_idx = 6'd29;
      8'h5A: w_idx = 6'd30;
      8'h4B: w_idx = 6'd31;
      8'h42: w_idx = 6'd32;
      8'h3B: w_idx = 6'd33;
      8'h33: w_idx = 6'd34;
      8'h29: w_idx = 6'd35;
      8'h3A: w_idx = 6'd36;
      8'h31: w_idx = 6'd37;
      8'h32: w_idx = 6'd38;
      8'h2A: w_idx = 6'd39;
      8'h66: w_idx = 6'd40;
      8'h76: w_idx = 6'd41;
      8'h6B: begin w_idx = 6'd42; w_hit = ps2_key[8]; end
      8'h72: begin w_idx = 6'd43; w_hit = ps2_key[8]; end
      8'h75: begin w_idx = 6'd44; w_hit = ps2_key[8]; end
      8'h74: begin w_idx = 6'd45; w_hit = ps2_key[8]; end
      default: w_hit = 1'b0;
    endcase
  end
  assign w_bit    = 46'd1 << w_idx;
  assign w_event  = r_armed && (ps2_key[10] != r_tog) && w_hit;
  assign w_press  = w_event && ps2_key[9];
  assign w_pend_n = r_pend | ((w_event && !ps2_key[9]) ? (w_bit & r_src) : 46'd0);
  assign w_expire = r_cnt <= CW'(1);
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_armed <= 1'b0;
      r_tog   <= 1'b0;
      r_src   <= '0;
      r_pend  <= '0;
      r_cnt   <= '0;
    end else begin
      r_armed <= 1'b1;
      r_tog   <= ps2_key[10];
      if (w_press) begin
        r_src  <= r_src | w_bit;
        r_pend <= r_pend & ~w_bit;
        r_cnt  <= HOLD;
      end else begin
        r_src  <= w_expire ? (r_src & ~w_pend_n) : r_src;
        r_pend <= w_expire ? '0 : w_pend_n;
        r_cnt  <= (r_cnt != '0) ? r_cnt - CW'(1) : r_cnt;
      end
    end
  end
  // Compound sources add SHIFT plus their key; joystick is a live, unshifted overlay.
  always_comb begin
    w_key     = r_src[39:0];
    w_key[0]  = r_src[0] | (|r_src[45:40]);
    w_key[20] = r_src[20] | r_src[40];
    w_key[35] = r_src[35] | r_src[41] | joystick[4];
    w_key[19] = r_src[19] | r_src[42] | joystick[1];
    w_key[24] = r_src[24] | r_src[43] | joystick[2];
    w_key[23] = r_src[23] | r_src[44] | joystick[3];
    w_key[22] = r_src[22] | r_src[45] | joystick[0];
    w_col = 5'h1F;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++)
        if (!kbd_row[r] && w_key[r*5+c]) w_col[c] = 1'b0;
  end
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_col <= 5'h1F;
    else r_col <= w_col;
  end
  assign kbd_col = r_col;
endmodule

// File: tb/tb_ace_kbd_matrix.sv
// tb_ace_kbd_matrix: scoreboard bench; a timestamp-based key model predicts kbd_col every clock.
module tb_ace_kbd_matrix;
  localparam int M = 100;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [15:0] joystick;
  logic [7:0]  kbd_row;
  logic [4:0]  kbd_col;
  int checks = 0;
  int failures = 0;
  logic [4:0] exp_q[$];
  logic [4:0] mon_exp;
  ace_kbd_matrix #(.MIN_HOLD(M)) dut (
    .clk_sys(clk), .reset_n(reset_n), .ps2_key(ps2_key),
    .joystick(joystick), .kbd_row(kbd_row), .kbd_col(kbd_col)
  );
  always #5 clk = ~clk;
  logic [7:0] codes [40] = '{8'h12, 8'h14, 8'h1A, 8'h22, 8'h21, 8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
                             8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                             8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36, 8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
                             8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33, 8'h29, 8'h3A, 8'h31, 8'h32, 8'h2A};
  logic [7:0] ccodes [6] = '{8'h66, 8'h76, 8'h6B, 8'h72, 8'h75, 8'h74};
  int comp_key [6] = '{4*5+0, 7*5+0, 3*5+4, 4*5+4, 4*5+3, 4*5+2};
  int joy_key [5] = '{4*5+2, 3*5+4, 4*5+4, 4*5+3, 7*5+0};
  bit held [46];
  bit pend [46];
  bit m_armed;
  bit m_tog;
  bit m_ev;
  int m_idx;
  longint cyc = 0;
  longint last_press = -1000000;
  function automatic int decode(logic [7:0] code, logic ext);
    if (code == 8'h59) return 0;
    if (code == 8'h12 && ext) return -1;
    for (int i = 0; i < 40; i++) if (codes[i] == code) return i;
    for (int j = 0; j < 6; j++) if (ccodes[j] == code) return (j < 2 || ext) ? 40 + j : -1;
    return -1;
  endfunction
  function automatic logic [4:0] exp_col();
    bit k [40];
    logic [4:0] col = 5'h1F;
    for (int i = 0; i < 40; i++) k[i] = held[i];
    for (int j = 0; j < 6; j++) if (held[40+j]) begin k[0] = 1; k[comp_key[j]] = 1; end
    for (int j = 0; j < 5; j++) if (joystick[j]) k[joy_key[j]] = 1;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++)
        if (!kbd_row[r] && k[r*5+c]) col[c] = 1'b0;
    return col;
  endfunction
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 46; i++) begin held[i] = 0; pend[i] = 0; end
      m_armed = 0;
      last_press = -1000000;
    end else begin
      exp_q.push_back(exp_col());
      if (!m_armed) begin
        m_armed = 1;
        m_tog = ps2_key[10];
      end else begin
        m_ev = ps2_key[10] != m_tog;
        m_tog = ps2_key[10];
        m_idx = decode(ps2_key[7:0], ps2_key[8]);
        if (m_ev && m_idx >= 0 && ps2_key[9]) begin
          held[m_idx] = 1;
          pend[m_idx] = 0;
          last_press = cyc;
        end else begin
          if (m_ev && m_idx >= 0 && held[m_idx]) pend[m_idx] = 1;
          if (cyc >= last_press + M)
            for (int i = 0; i < 46; i++) if (pend[i]) begin held[i] = 0; pend[i] = 0; end
        end
      end
    end
    cyc++;
  end
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      checks++;
      if (kbd_col !== 5'h1F) begin
        failures++;
        $display("FAIL reset_col cycle=%0d got=%h expected=1f", cyc, kbd_col);
      end
    end else if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      checks++;
      if (kbd_col !== mon_exp) begin
        failures++;
        $display("FAIL kbd_col cycle=%0d row=%h joy=%h got=%h expected=%h", cyc, kbd_row, joystick[4:0], kbd_col, mon_exp);
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic key(input bit p, input bit x, input logic [7:0] c);
    ps2_key = {~ps2_key[10], p, x, c};
  endtask
  logic [7:0] pool [16] = '{8'h1C, 8'h15, 8'h12, 8'h59, 8'h14, 8'h66, 8'h76, 8'h6B,
                            8'h72, 8'h75, 8'h74, 8'h29, 8'h45, 8'h2E, 8'h0D, 8'h5A};
  initial begin
    reset_n = 1'b0;
    ps2_key = 11'h400;
    kbd_row = 8'h00;
    joystick = 16'h0;
    step(3);
    reset_n = 1'b1;
    step(5);
    kbd_row = 8'hFD; key(1, 0, 8'h1C); step(5);
    kbd_row = 8'hFE; step(3);
    kbd_row = 8'hFD; key(0, 0, 8'h1C); step(M + 5);
    kbd_row = 8'hFB; key(1, 0, 8'h15); step(10); key(0, 0, 8'h15); step(M + 5);
    kbd_row = 8'hF6; key(1, 1, 8'h6B); step(5); key(0, 1, 8'h6B); step(M + 5);
    kbd_row = 8'hEE; key(1, 0, 8'h12); step(3); key(1, 0, 8'h66); step(3); key(0, 0, 8'h66);
    step(M + 10); key(0, 0, 8'h12); step(5);
    kbd_row = 8'h7F; joystick = 16'h0010; step(3); joystick = 16'h0; step(3);
    kbd_row = 8'hF9; key(1, 0, 8'h15); step(10); key(0, 0, 8'h15); step(M - 10);
    key(1, 0, 8'h1D); step(20); key(0, 0, 8'h1D); step(M + 5);
    kbd_row = 8'h00; key(1, 1, 8'h12); step(3); key(1, 0, 8'h6B); step(3); key(1, 0, 8'h0D); step(5);
    key(1, 0, 8'h1A); step(4); key(0, 0, 8'h1A); step(20);
    reset_n = 1'b0; step(2); reset_n = 1'b1; step(M + 5);
    for (int n = 0; n < 400; n++) begin
      key($urandom_range(0, 1), $urandom_range(0, 1), pool[$urandom_range(0, 15)]);
      if ($urandom_range(0, 3) == 0) kbd_row = 8'($urandom);
      if ($urandom_range(0, 5) == 0) joystick = {11'h0, 5'($urandom)};
      step($urandom_range(2, 60));
    end
    joystick = 16'h0;
    step(M + 5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
